// File: rtl/press_classifier.sv
// Press classifier: turns a debounced button level into press / short / long / double events.
// Optional `PRESS_CNT_EN adds an 8-bit wrapping press counter output (press_cnt).
module press_classifier #(
  parameter int LONG_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 30_000_000,
  parameter int CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       db_in,
  output logic       press_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       busy
`ifdef PRESS_CNT_EN
  ,
  output logic [7:0] press_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_GAP       = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             prev;
  logic             rise;
  logic             press_n, short_n, long_n, double_n, busy_n;

  assign rise = db_in & ~prev;

  // prev resets high so a button held through reset is not taken as a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      prev  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      prev  <= db_in;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = PRESSED;
          cnt_n   = CNT_ONE;
        end
      end
      PRESSED: begin
        if (db_in) begin
          if (cnt == LONG_LAST) state_n = LONG_HELD;
          else                  cnt_n   = cnt + CNT_ONE;
        end else begin
          // The release edge already counts as the first low sample.
          state_n = WAIT_GAP;
          cnt_n   = CNT_ONE;
        end
      end
      LONG_HELD: begin
        if (!db_in) state_n = IDLE;
      end
      WAIT_GAP: begin
        // A high on the final gap edge wins over the timeout.
        if (db_in)                 state_n = SECOND_PRESSED;
        else if (cnt == GAP_LAST)  state_n = IDLE;
        else                       cnt_n   = cnt + CNT_ONE;
      end
      SECOND_PRESSED: begin
        if (!db_in) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    press_n  = 1'b0;
    short_n  = 1'b0;
    long_n   = 1'b0;
    double_n = 1'b0;
    busy_n   = (state_n != IDLE);
    case (state)
      IDLE:     press_n = rise;
      PRESSED:  long_n  = db_in && (cnt == LONG_LAST);
      WAIT_GAP: begin
        press_n  = db_in;
        double_n = db_in;
        short_n  = !db_in && (cnt == GAP_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press_pulse  <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      press_pulse  <= press_n;
      short_press  <= short_n;
      long_press   <= long_n;
      double_press <= double_n;
      busy         <= busy_n;
    end
  end

`ifdef PRESS_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         press_cnt <= 8'd0;
    else if (press_n) press_cnt <= press_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: vector table, hand-written corner sequences and a
// randomized run checked against a run-length reference model.
module tb_press_classifier;
  localparam int LONG = 8;
  localparam int GAP  = 5;
  localparam int MAXN = 2000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic db_in = 1'b0;
  logic press_pulse, short_press, long_press, double_press, busy;
`ifdef PRESS_CNT_EN
  logic [7:0] press_cnt;
`endif

  int checks = 0;
  int failures = 0;

  press_classifier #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .db_in(db_in),
    .press_pulse(press_pulse),
    .short_press(short_press),
    .long_press(long_press),
    .double_press(double_press),
    .busy(busy)
`ifdef PRESS_CNT_EN
    ,
    .press_cnt(press_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] stim;
    int          len;
    logic [23:0] e_press;
    logic [23:0] e_short;
    logic [23:0] e_long;
    logic [23:0] e_double;
    logic [23:0] e_busy;
  } vec_t;

  vec_t vecs[8];

  bit stim_a[MAXN];
  bit m_press[MAXN], m_short[MAXN], m_long[MAXN], m_double[MAXN], m_busy[MAXN];

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic ep, input logic es,
                           input logic el, input logic ed, input logic eb);
    check({tag, ".press_pulse"}, idx, press_pulse, ep);
    check({tag, ".short_press"}, idx, short_press, es);
    check({tag, ".long_press"}, idx, long_press, el);
    check({tag, ".double_press"}, idx, double_press, ed);
    check({tag, ".busy"}, idx, busy, eb);
  endtask

  // Asserts reset off-edge, checks outputs cleared at once, releases just after a posedge.
  task automatic do_reset(input logic level);
    @(negedge clk);
    db_in = level;
    rst = 1'b0;
    #1;
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic step(input logic v);
    @(negedge clk);
    db_in = v;
    @(posedge clk);
    #1;
  endtask

  // Event timeline derived from press/release run lengths.
  task automatic build_model(input int n);
    int k, s, h, r, d, r2;
    bit prev;
    for (int i = 0; i < n; i++) begin
      m_press[i] = 0; m_short[i] = 0; m_long[i] = 0; m_double[i] = 0; m_busy[i] = 0;
    end
    k = 0;
    prev = 1'b1;
    while (k < n) begin
      if (stim_a[k] && !prev) begin
        s = k;
        m_press[s] = 1;
        h = 0;
        while (s + h < n && stim_a[s + h]) h++;
        r = s + h;
        if (h >= LONG) begin
          m_long[s + LONG - 1] = 1;
          for (int i = s; i < r && i < n; i++) m_busy[i] = 1;
          k = r + 1;
        end else begin
          d = -1;
          for (int i = r + 1; i <= r + GAP - 1 && i < n; i++)
            if (d < 0 && stim_a[i]) d = i;
          if (d >= 0) begin
            m_press[d] = 1;
            m_double[d] = 1;
            r2 = d;
            while (r2 < n && stim_a[r2]) r2++;
            for (int i = s; i < r2 && i < n; i++) m_busy[i] = 1;
            k = r2 + 1;
          end else begin
            if (r + GAP - 1 < n) m_short[r + GAP - 1] = 1;
            for (int i = s; i <= r + GAP - 2 && i < n; i++) m_busy[i] = 1;
            k = r + GAP;
          end
        end
        prev = 1'b0;
      end else begin
        prev = stim_a[k];
        k++;
      end
    end
  endtask

  initial begin
    // short, long, double, gap timeout + fresh rise, double on final gap edge,
    // one-cycle press, exactly LONG highs, LONG-1 highs.
    vecs[0] = '{24'h00000E, 16, 24'h000002, 24'h000100, 24'h000000, 24'h000000, 24'h0000FE};
    vecs[1] = '{24'h0007FE, 16, 24'h000002, 24'h000000, 24'h000100, 24'h000000, 24'h0007FE};
    vecs[2] = '{24'h0000CE, 20, 24'h000042, 24'h000000, 24'h000000, 24'h000040, 24'h0000FE};
    vecs[3] = '{24'h000E0E, 20, 24'h000202, 24'h010100, 24'h000000, 24'h000000, 24'h00FEFE};
    vecs[4] = '{24'h00030E, 20, 24'h000102, 24'h000000, 24'h000000, 24'h000100, 24'h0003FE};
    vecs[5] = '{24'h000002, 16, 24'h000002, 24'h000040, 24'h000000, 24'h000000, 24'h00003E};
    vecs[6] = '{24'h0001FE, 16, 24'h000002, 24'h000000, 24'h000100, 24'h000000, 24'h0001FE};
    vecs[7] = '{24'h0000FE, 20, 24'h000002, 24'h001000, 24'h000000, 24'h000000, 24'h000FFE};

    for (int v = 0; v < 8; v++) begin
      do_reset(1'b0);
      for (int k = 0; k < vecs[v].len; k++) begin
        step(vecs[v].stim[k]);
        check_all($sformatf("vec%0d", v), k, vecs[v].e_press[k], vecs[v].e_short[k],
                  vecs[v].e_long[k], vecs[v].e_double[k], vecs[v].e_busy[k]);
      end
    end

    // After the short timeout, the next high is a fresh press that can still go long.
    do_reset(1'b0);
    step(1'b0);
    repeat (3) step(1'b1);
    repeat (5) step(1'b0);
    check("gap.short_at_timeout", 0, short_press, 1'b1);
    step(1'b1);
    check("gap.fresh_press", 0, press_pulse, 1'b1);
    check("gap.fresh_busy", 0, busy, 1'b1);
    check("gap.fresh_not_double", 0, double_press, 1'b0);
    repeat (LONG - 1) step(1'b1);
    check("gap.then_long", 0, long_press, 1'b1);

    // Button held through reset release is ignored until released and pressed again.
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      check_all("held", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0);
    check("held.release_no_press", 0, press_pulse, 1'b0);
    step(1'b1);
    check("held.new_press", 0, press_pulse, 1'b1);

    // Reset in the middle of PRESSED clears outputs without an edge and drops the event.
    do_reset(1'b0);
    step(1'b0);
    step(1'b1);
    check("mid.press", 0, press_pulse, 1'b1);
    step(1'b1);
    check("mid.busy", 0, busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_all("mid.async", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    db_in = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step(1'b0);
      check_all("mid.after", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Randomized runs of high/low against the reference model.
    begin
      int n;
      bit lvl;
      n = 0;
      lvl = bit'($urandom_range(0, 1));
      while (n < MAXN) begin
        int run;
        run = $urandom_range(1, 12);
        for (int i = 0; i < run && n < MAXN; i++) begin
          stim_a[n] = lvl;
          n++;
        end
        lvl = ~lvl;
      end
      build_model(MAXN);
      do_reset(1'b0);
      for (int k = 0; k < MAXN; k++) begin
        step(stim_a[k]);
        check_all("rand", k, m_press[k], m_short[k], m_long[k], m_double[k], m_busy[k]);
      end
    end

`ifdef PRESS_CNT_EN
    begin
      logic [7:0] exp_cnt;
      exp_cnt = 8'd0;
      do_reset(1'b0);
      check("cnt.reset", 0, press_cnt == 8'd0, 1'b1);
      for (int p = 0; p < 257; p++) begin
        step(1'b1);
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (press_cnt !== exp_cnt) begin
          failures++;
          $display("FAIL cnt press %0d: got %0d expected %0d", p, press_cnt, exp_cnt);
        end
        repeat (GAP + 1) step(1'b0);
      end
      check("cnt.after_wrap_is_1", 0, press_cnt == 8'd1, 1'b1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
Name: press_classifier

Overview:
- Sits directly downstream of the push-button debouncer and consumes its clean, clock-synchronous level `db_in`.
- Turns each press into a one-cycle press pulse.
- Classifies each press as short, long, or double-press, and emits one single-cycle event per classification.
- Events drive mode/counter logic in lab top-levels.

Parameters:
- LONG_CYCLES, 100_000_000, consecutive high samples of `db_in` that make a long press; must be ≥2.
- GAP_CYCLES, 30_000_000, consecutive low samples after release that end a short press; must be ≥2.
- CNT_W, 27, width of the internal cycle counter; must hold max(LONG_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- db_in  input  1  debounced button level, already synchronous to clk
- press_pulse  output  1  one-cycle pulse on every accepted press start
- short_press  output  1  one-cycle pulse: single press, released before long threshold, no second press in the gap
- long_press  output  1  one-cycle pulse: press held LONG_CYCLES samples
- double_press  output  1  one-cycle pulse: second press started inside the gap window
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, prev=1.
  - All outputs 0 immediately.
  - Any in-flight classification is discarded with no event.
- All outputs are registered. An event appears in the cycle after the clk edge that samples its triggering condition and lasts exactly one cycle.
- prev is a registered copy of `db_in`. rise = db_in & ~prev.
  - prev resets to 1, so a button held through reset release is ignored until it is released and pressed again.
- States:
  - IDLE:
    - On rise: press_pulse<=1, cnt<=1, go to PRESSED.
  - PRESSED:
    - db_in=1 and cnt==LONG_CYCLES-1: long_press<=1, go to LONG_HELD.
    - db_in=1 otherwise: cnt<=cnt+1.
    - db_in=0: cnt<=1, go to WAIT_GAP. This release edge is low sample 1.
  - LONG_HELD:
    - Wait for db_in=0, then go to IDLE.
    - No short or double event is produced.
  - WAIT_GAP:
    - db_in=1: press_pulse<=1, double_press<=1 (same cycle), go to SECOND_PRESSED.
    - db_in=0 and cnt==GAP_CYCLES-1: short_press<=1, go to IDLE.
    - db_in=0 otherwise: cnt<=cnt+1.
  - SECOND_PRESSED:
    - Wait for db_in=0, then go to IDLE.
    - No long detection; a third press needs a fresh rise from IDLE.
- Timing, with release sampled at edge R:
  - A rise sampled at edges R+1 … R+GAP_CYCLES-1 produces double_press.
  - Low at all of edges R … R+GAP_CYCLES-1 produces short_press after edge R+GAP_CYCLES-1.
- Simultaneous events: the db_in=1 check has priority over the timeout at the same edge, so a rise on the final gap edge counts as a double press.
- After the short timeout returns the FSM to IDLE, prev=0. A high on the very next edge is a new rise.
- busy is registered as (next_state != IDLE). It drops in the same cycle as short_press, or one cycle after the release edge in LONG_HELD and SECOND_PRESSED.
- cnt never wraps: every path that would exceed its threshold leaves the state first.

Optional Feature:
- Macro: PRESS_CNT_EN.
- Defined:
  - Adds output `press_cnt [7:0]`, reset 0.
  - Increments in the same cycle press_pulse is registered high.
  - Wraps 255→0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
All scenarios use LONG_CYCLES=8, GAP_CYCLES=5, CNT_W=4.
- Short press: release reset with db_in=0; drive db_in high for 3 edges, then low.
  - press_pulse=1 for exactly 1 cycle after the first high sample.
  - short_press=1 for 1 cycle after the 5th low sample.
  - long_press and double_press stay 0; busy=0 afterwards.
- Long press: db_in high for 10 edges, then low.
  - long_press pulses after the 8th high sample.
  - No short_press after release; busy falls 1 cycle after release.
- Double press: high 3 edges, low 2 edges, high 2 edges, low 10 edges.
  - press_pulse fires twice; double_press coincides with the second press_pulse.
  - No short_press.
- Gap boundary: high 3 edges, then low exactly 5 edges, then high.
  - short_press fires at the timeout.
  - The next high edge gives a fresh press_pulse, and the FSM is in PRESSED.
  - Repeat with the high arriving on the 5th low edge instead: double_press, no short_press.
- Reset interactions:
  - Hold db_in=1 across reset release: no press_pulse until db_in goes 0 then 1.
  - Assert rst mid-PRESSED: all outputs 0 without waiting for a clk edge, and no event fires after reset release.
- PRESS_CNT_EN build: issue 257 presses.
  - press_cnt reads 1 after the wrap (count sequence ends 255→0→1).
